block_interleaver: RTL
======================

Name: block_interleaver

Overview:
- Byte-wide row/column block interleaver.
- Sits directly downstream of the 8-bit input register stage.
- Accepts a stream of bytes, writes each block of ROWS*COLS bytes row-major into one bank of a ping-pong buffer, and reads the block out column-major.
- The second bank lets writing of block n+1 overlap reading of block n.

Parameters:
DATA_W  8  width of each symbol
ROWS  4  rows in the interleave matrix (>=2)
COLS  8  columns in the interleave matrix (>=2); block size N = ROWS*COLS

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset)
in_data  input  DATA_W  input symbol
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a symbol this cycle
out_data  output  DATA_W  interleaved symbol
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  high with the last symbol (N-1) of each output block

Behaviour:
- Reset (reset=0, async): bank_full[1:0]=0, wr_bank=0, rd_bank=0, all counters 0, out_valid=0, out_data=0, out_last=0, in_ready=1 after release. Memory contents are not reset.
- Storage: 2 banks x N x DATA_W, registers or inferred RAM; one write port and one read port.
- Write side:
  - in_ready = !bank_full[wr_bank], combinational from registered flags.
  - Handshake = in_valid & in_ready. Each handshake writes mem[wr_bank][wr_row*COLS+wr_col].
  - wr_col increments and wraps at COLS-1, then wr_row increments.
  - On the handshake at wr_row=ROWS-1, wr_col=COLS-1: set bank_full[wr_bank], toggle wr_bank, clear counters.
- Read side:
  - Read address = rd_row*COLS+rd_col. rd_row increments first and wraps at ROWS-1, then rd_col increments (column-major order).
  - Output register loads when bank_full[rd_bank] & (!out_valid | out_ready): out_data <= mem[rd_bank][addr], out_valid <= 1, out_last <= (rd_row=ROWS-1 & rd_col=COLS-1).
  - On the load of the last element: clear bank_full[rd_bank], toggle rd_bank, clear counters.
  - If no load occurs and out_ready=1, out_valid <= 0.
- Ordering rules:
  - Output symbol k of a block equals input symbol (k mod ROWS)*COLS + k/ROWS.
  - out_data and out_last hold stable while out_valid & !out_ready.
- Latency:
  - Last input handshake in cycle t -> first output out_valid=1 in cycle t+2.
  - Throughput is 1 symbol/cycle sustained with out_ready=1.
- Boundary conditions:
  - Both banks full: in_ready=0 until the reader clears a bank. in_ready rises the cycle after that clear.
  - Write-complete and read-complete in the same cycle touch different banks. Both flag updates take effect.
  - Writer and reader never access the same bank simultaneously; the full flags guarantee this.
  - Reset mid-block discards all partial and full blocks.
  - in_data is ignored when in_ready=0.

Optional Feature:
- Macro BLKINT_DEINT_EN.
- Defined:
  - Adds input port deint (1 bit), sampled into a per-bank mode bit at the moment that bank becomes full.
  - Mode=1 selects the inverse permutation: read address = rd_col*ROWS+rd_row, where rd_col increments first and wraps at COLS-1, then rd_row increments. This deinterleaves a stream produced with mode=0.
  - out_last is unchanged.
- Undefined: no deint port; only the column-major interleave order exists.

Test Plan:
- ROWS=4, COLS=8, inputs 0..31 back-to-back, out_ready=1 -> outputs 0,8,16,24,1,9,...,7,15,23,31; out_last only with 31; first out_valid 2 cycles after the input handshake of 31.
- Three blocks 0..95 streamed continuously, out_ready=1 -> in_ready stays 1 through blocks 1 and 2; block 3 stalls in_ready=0 until block 1's last output loads; all 96 outputs in correct order, no gaps during blocks 1-2.
- out_ready toggled randomly (about 50%) during block output -> out_data/out_last stable while stalled; sequence identical to the first test.
- Assert reset=0 after 13 input symbols, then send a fresh block 100..131 -> out_valid=0 during and after reset until the new block completes; outputs 100,108,116,124,101,...; no stale data.
- BLKINT_DEINT_EN: feed output of the first test (0,8,16,...,31) with deint=1 -> outputs 0,1,2,...,31 in order.
- in_valid=1 with in_ready=0 and changing in_data -> none of the rejected values appear at the output.

Source files
------------

// File: rtl/block_interleaver.sv
// Row/column block interleaver with a ping-pong buffer.
// Each block of ROWS*COLS symbols is written row-major into one bank and
// read out column-major from the other bank, so writing block n+1
// overlaps reading block n.
// Optional build macro: BLKINT_DEINT_EN adds a 'deint' input. That input
// selects, per bank, the inverse (deinterleave) read order.
module block_interleaver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef BLKINT_DEINT_EN
  input  logic              deint,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  // Symbol storage: two banks, one write port, one read port.
  logic [DATA_W-1:0] mem [2][N];

  // Control state and its next-state values.
  logic [1:0]        bank_full, bank_full_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic [RW-1:0]     wr_row, wr_row_nxt;
  logic [CW-1:0]     wr_col, wr_col_nxt;
  logic [RW-1:0]     rd_row, rd_row_nxt;
  logic [CW-1:0]     rd_col, rd_col_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              out_valid_nxt;
  logic              out_last_nxt;

  logic              wr_fire;
  logic              wr_last;
  logic              rd_load;
  logic              rd_last;
  logic              rd_colfirst;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] rd_word;

`ifdef BLKINT_DEINT_EN
  // Per-bank read-order mode, captured when the bank fills.
  logic [1:0] mode, mode_nxt;
  assign rd_colfirst = mode[rd_bank];
`else
  assign rd_colfirst = 1'b0;
`endif

  assign in_ready = ~bank_full[wr_bank];
  assign wr_fire  = in_valid & in_ready;
  assign wr_last  = (wr_row == ROW_MAX) && (wr_col == COL_MAX);
  assign rd_load  = bank_full[rd_bank] & (~out_valid | out_ready);
  assign rd_last  = (rd_row == ROW_MAX) && (rd_col == COL_MAX);

  // Write address is always row-major.
  assign waddr = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

  // Read address: row-major address walked column-first (interleave), or
  // column-major address walked row-first (deinterleave).
  always_comb begin
    raddr = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
    if (rd_colfirst) begin
      raddr = AW'(rd_col) * AW'(ROWS) + AW'(rd_row);
    end
  end

  assign rd_word = mem[rd_bank][raddr];

  // Buffer write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][waddr] <= in_data;
    end
  end

  // Next-state logic for the write counters, read counters, bank flags and output register.
  always_comb begin
    bank_full_nxt = bank_full;
    wr_bank_nxt   = wr_bank;
    rd_bank_nxt   = rd_bank;
    wr_row_nxt    = wr_row;
    wr_col_nxt    = wr_col;
    rd_row_nxt    = rd_row;
    rd_col_nxt    = rd_col;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
`ifdef BLKINT_DEINT_EN
    mode_nxt      = mode;
`endif

    // Writer: row-major fill; close the bank on its last symbol.
    if (wr_fire) begin
      if (wr_last) begin
        bank_full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt            = ~wr_bank;
        wr_row_nxt             = '0;
        wr_col_nxt             = '0;
`ifdef BLKINT_DEINT_EN
        mode_nxt[wr_bank]      = deint;
`endif
      end else if (wr_col == COL_MAX) begin
        wr_col_nxt = '0;
        wr_row_nxt = wr_row + RW'(1);
      end else begin
        wr_col_nxt = wr_col + CW'(1);
      end
    end

    // Reader: load the output register whenever it is empty or being drained.
    if (rd_load) begin
      out_data_nxt  = rd_word;
      out_valid_nxt = 1'b1;
      out_last_nxt  = rd_last;
      if (rd_last) begin
        bank_full_nxt[rd_bank] = 1'b0;
        rd_bank_nxt            = ~rd_bank;
        rd_row_nxt             = '0;
        rd_col_nxt             = '0;
      end else if (rd_colfirst) begin
        if (rd_col == COL_MAX) begin
          rd_col_nxt = '0;
          rd_row_nxt = rd_row + RW'(1);
        end else begin
          rd_col_nxt = rd_col + CW'(1);
        end
      end else begin
        if (rd_row == ROW_MAX) begin
          rd_row_nxt = '0;
          rd_col_nxt = rd_col + CW'(1);
        end else begin
          rd_row_nxt = rd_row + RW'(1);
        end
      end
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef BLKINT_DEINT_EN
      mode      <= '0;
`endif
    end else begin
      bank_full <= bank_full_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_bank   <= rd_bank_nxt;
      wr_row    <= wr_row_nxt;
      wr_col    <= wr_col_nxt;
      rd_row    <= rd_row_nxt;
      rd_col    <= rd_col_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
`ifdef BLKINT_DEINT_EN
      mode      <= mode_nxt;
`endif
    end
  end

endmodule
